reset_sequencer: RTL and testbench

- Sequences board-level reset release after the power-on reset timer deasserts.
- Waits for PLL lock, then releases STAGES downstream reset domains one at a time, in order, with a fixed spacing between them.
- Supervises lock while releasing and while running; raises a fault on lock timeout or loss of lock.
- Sits between the POR timer and all per-domain reset consumers (clock tree, ADC front end, DSP, bus interface).

---
 rtl/reset_sequencer.sv | 137 +++++++++++++
 tb/tb_reset_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for POR release and PLL lock, then releases
// each reset domain in order; lock is supervised and failures latch a fault.
//
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   por_rst      : power-on reset hold (active high, synchronous to clk)
//   pll_locked   : raw PLL lock indicator (asynchronous)
//   sw_reset_req : one-cycle request to rerun the whole sequence
//   stage_rst    : per-domain resets (active high, bit 0 released first)
//   ready        : high in RUN only
//   fault        : sticky lock fault
//   state        : debug code (HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4)
module reset_sequencer #(
  parameter int STAGES       = 4,
  parameter int STAGE_DELAY  = 1000,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              por_rst,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  output logic [STAGES-1:0] stage_rst,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int MAXC = (STAGE_DELAY > LOCK_TIMEOUT) ?
                        STAGE_DELAY : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;
  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [STAGES-1:0] ALL = {STAGES{1'b1}};
  localparam logic [CW-1:0] DLY_END = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_END = IW'(STAGES - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } st_t;

  st_t                    st;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;

  assign lock_s = sync[SYNC_STAGES-1];
  assign state  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      stage_rst <= ALL;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else if (por_rst || (sw_reset_req && st != HOLD)) begin
      st        <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      stage_rst <= ALL;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else if (!lock_s && (st == RELEASE || st == RUN)) begin
      st        <= FAULT;
      cnt       <= '0;
      stage_rst <= ALL;
      ready     <= 1'b0;
      fault     <= 1'b1;
    end else begin
      unique case (st)
        HOLD: begin
          stage_rst <= ALL;
          ready     <= 1'b0;
          st        <= WAIT_LOCK;
          cnt       <= '0;
        end
        WAIT_LOCK: begin
          cnt <= cnt + 1'b1;
          // lock wins over a coincident timeout
          if (lock_s) begin
            st  <= RELEASE;
            cnt <= '0;
            idx <= '0;
          end else if (cnt == TMO_END) begin
            st    <= FAULT;
            cnt   <= '0;
            fault <= 1'b1;
          end
        end
        RELEASE: begin
          cnt <= cnt + 1'b1;
          if (cnt == DLY_END) begin
            stage_rst[idx] <= 1'b0;
            cnt            <= '0;
            idx            <= idx + 1'b1;
            if (idx == IDX_END) begin
              st    <= RUN;
              ready <= 1'b1;
            end
          end
        end
        RUN: begin
          ready     <= 1'b1;
          stage_rst <= '0;
        end
        FAULT: begin
          fault     <= 1'b1;
          ready     <= 1'b0;
          stage_rst <= ALL;
        end
        default: begin
          st        <= HOLD;
          stage_rst <= ALL;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: bring-up, resequence, lock loss,
// lock timeout, POR during release and async reset.
module tb_reset_sequencer;

  localparam int STAGES = 4;
  localparam int DLY    = 8;
  localparam int TMO    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              por_rst;
  logic              pll_locked;
  logic              sw_reset_req;
  logic [STAGES-1:0] stage_rst;
  logic              ready;
  logic              fault;
  logic [2:0]        state;

  int vectors = 0;
  int miscompares = 0;

  reset_sequencer #(
    .STAGES(STAGES),
    .STAGE_DELAY(DLY),
    .LOCK_TIMEOUT(TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .por_rst(por_rst),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .stage_rst(stage_rst),
    .ready(ready),
    .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag,
                            input logic [2:0] s,
                            input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  // Checks the staged release from just after RELEASE entry to RUN.
  task automatic release_seq(input string tag);
    logic [STAGES-1:0] prev;
    logic [STAGES-1:0] nxt;
    prev = 4'hF;
    for (int k = 0; k < STAGES; k++) begin
      repeat (DLY - 1) tick();
      chk({tag, "_hold"}, 32'(stage_rst), 32'(prev));
      tick();
      nxt = prev << 1;
      chk({tag, "_rel"}, 32'(stage_rst), 32'(nxt));
      prev = nxt;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_run"}, 32'(state), 32'd3);
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    por_rst      = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    #12;
    chk("rst_stage", 32'(stage_rst), 32'hF);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_state", 32'(state), 32'd0);

    // nominal bring-up
    rst_n = 1'b1;
    repeat (10) tick();
    chk("por_hold", 32'(state), 32'd0);
    sw_pulse();
    chk("sw_in_hold", 32'(state), 32'd0);
    por_rst = 1'b0;
    tick();
    chk("wait_lock", 32'(state), 32'd1);
    repeat (5) tick();
    chk("still_wait", 32'(state), 32'd1);
    pll_locked = 1'b1;
    wait_state("enter_rel", 3'd2, 6);
    chk("rel_ready0", 32'(ready), 32'd0);
    release_seq("boot");

    // software resequence from RUN
    sw_pulse();
    chk("sw_state", 32'(state), 32'd0);
    chk("sw_stage", 32'(stage_rst), 32'hF);
    chk("sw_ready", 32'(ready), 32'd0);
    tick();
    chk("sw_wait", 32'(state), 32'd1);
    tick();
    chk("sw_rel", 32'(state), 32'd2);
    release_seq("reseq");

    // lock lost mid-release
    sw_pulse();
    wait_state("ll_rel", 3'd2, 6);
    repeat (2 * DLY) tick();
    chk("ll_two_rel", 32'(stage_rst), 32'hC);
    pll_locked = 1'b0;
    wait_state("ll_fault", 3'd4, 4);
    chk("ll_stage", 32'(stage_rst), 32'hF);
    chk("ll_fault_flag", 32'(fault), 32'd1);
    chk("ll_ready", 32'(ready), 32'd0);
    repeat (3) tick();
    chk("ll_sticky", 32'(fault), 32'd1);

    // lock timeout
    sw_pulse();
    chk("to_clr_fault", 32'(fault), 32'd0);
    chk("to_hold", 32'(state), 32'd0);
    tick();
    chk("to_wait", 32'(state), 32'd1);
    repeat (TMO - 1) tick();
    chk("to_pre", 32'(state), 32'd1);
    tick();
    chk("to_state", 32'(state), 32'd4);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_stage", 32'(stage_rst), 32'hF);
    sw_pulse();
    chk("to_sw_fault", 32'(fault), 32'd0);
    chk("to_sw_state", 32'(state), 32'd0);

    // POR during release
    pll_locked = 1'b1;
    wait_state("por_rel", 3'd2, 6);
    repeat (DLY) tick();
    chk("por_bit0", 32'(stage_rst), 32'hE);
    por_rst = 1'b1;
    tick();
    chk("por_state", 32'(state), 32'd0);
    chk("por_stage", 32'(stage_rst), 32'hF);
    repeat (5) tick();
    chk("por_held", 32'(state), 32'd0);
    por_rst = 1'b0;
    tick();
    chk("por_wait", 32'(state), 32'd1);
    tick();
    chk("por_rel2", 32'(state), 32'd2);
    release_seq("por");

    // async reset in RUN, checked before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stage", 32'(stage_rst), 32'hF);
    chk("ar_ready", 32'(ready), 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    chk("ar_state", 32'(state), 32'd0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
